control_conteo: RTL

Run/stop/clear sequencer for the 4-digit BCD counter. Turns raw push-buttons into clean one-cycle events, runs a small FSM (IDLE/RUN/PAUSE), and issues single-cycle `count_en` and `clear` strobes to the counter. All logic runs on the 50 MHz board clock, replacing the gated-clock count path with a clock-enable path.

---
 rtl/control_conteo.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/control_conteo.sv
// Run/stop/clear sequencer for the 4-digit BCD counter: button conditioning, IDLE/RUN/PAUSE FSM,
// single-cycle count_en/clear strobes. Optional macro CONTROL_CONTEO_STOP_AT_MAX_EN halts at 9999.
module control_conteo #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int TICK_DIV   = 5_000_000
) (
    input  logic       clk50MHz,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_clr,
    input  logic       puls_ext,
    input  logic       sel1,
    input  logic       fin_cuenta,
    output logic       count_en,
    output logic       clear,
    output logic [1:0] estado,
    output logic       running
);

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int N_BTN  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    // Channel order: 0 = run/stop, 1 = clear, 2 = manual step
    logic [N_BTN-1:0] w_btn_raw;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_deb;
    logic [N_BTN-1:0] r_deb_d;
    logic [DEB_W-1:0] r_deb_cnt [N_BTN];
    logic [N_BTN-1:0] w_ev;

    logic              r_sel_s1;
    logic              r_sel_s2;
    logic [TICK_W-1:0] r_presc;
    logic              w_tick;
    logic              w_ev_run;
    logic              w_ev_clr;
    logic              w_ev_step;
    logic              w_count_req;

    state_t r_state;
    logic   r_count_en;
    logic   r_clear;

    assign w_btn_raw = {puls_ext, btn_clr, btn_run};

    // Synchronizer + debouncer per button. The debounced level moves only after the
    // synchronized level has disagreed with it for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        r_deb[i]     <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_ev      = r_deb & ~r_deb_d;
    assign w_ev_run  = w_ev[0];
    assign w_ev_clr  = w_ev[1];
    assign w_ev_step = w_ev[2];

    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            r_sel_s1 <= 1'b0;
            r_sel_s2 <= 1'b0;
        end else begin
            r_sel_s1 <= sel1;
            r_sel_s2 <= r_sel_s1;
        end
    end

    // Prescaler is held at zero outside RUN so every entry into RUN starts a full period.
    assign w_tick = (r_state == S_RUN) && (r_presc == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk50MHz) begin
        if (reset || (r_state != S_RUN)) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + TICK_W'(1);
        end
    end

    // Ticks still arrive in manual mode; the mode select simply ignores them.
    assign w_count_req = r_sel_s2 ? w_ev_step : w_tick;

`ifndef CONTROL_CONTEO_STOP_AT_MAX_EN
    logic w_unused_fin_cuenta;
    assign w_unused_fin_cuenta = fin_cuenta;
`endif

    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count_en <= 1'b0;
            r_clear    <= 1'b0;
        end else begin
            r_count_en <= 1'b0;
            r_clear    <= 1'b0;
            if (w_ev_clr) begin
                r_state <= S_IDLE;
                r_clear <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_ev_run) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (w_ev_run) begin
                            r_state <= S_PAUSE;
                        end else if (w_count_req) begin
`ifdef CONTROL_CONTEO_STOP_AT_MAX_EN
                            // Counter already shows 9999: freeze there instead of wrapping
                            if (fin_cuenta) begin
                                r_state <= S_PAUSE;
                            end else begin
                                r_count_en <= 1'b1;
                            end
`else
                            r_count_en <= 1'b1;
`endif
                        end
                    end
                    S_PAUSE: begin
                        if (w_ev_run) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign count_en = r_count_en;
    assign clear    = r_clear;
    assign estado   = r_state;
    assign running  = (r_state == S_RUN);

endmodule
